// File: rtl/noc_downstream_port_if.sv
// Router-to-downstream-port bundle: flit injection from the router, credit-style
// status back to it, and the drained-flit stream toward the sink.
interface noc_downstream_port_if #(
    parameter int VC_NUM = 2,
    parameter int DATA_W = 32
);
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic              valid_flit_i;
    logic [DATA_W-1:0] data_i;
    logic [VW-1:0]     vc_id_i;
    logic [1:0]        label_i;
    logic [VC_NUM-1:0] on_off_o;
    logic [VC_NUM-1:0] vc_allocatable_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [VW-1:0]     out_vc_o;
    logic [1:0]        out_label_o;
    logic              err_o;

    // Drain handshake: a flit transfers on a clock edge where out_valid_o and
    // out_ready_i are both high; while out_valid_o=1 and out_ready_i=0 the out_*
    // fields hold. The flit input has no ready: on_off_o is the only throttle.
    modport master (
        output valid_flit_i, data_i, vc_id_i, label_i, out_ready_i,
        input  on_off_o, vc_allocatable_o, out_valid_o, out_data_o, out_vc_o,
               out_label_o, err_o
    );
    modport slave (
        input  valid_flit_i, data_i, vc_id_i, label_i, out_ready_i,
        output on_off_o, vc_allocatable_o, out_valid_o, out_data_o, out_vc_o,
               out_label_o, err_o
    );
endinterface

// File: rtl/noc_downstream_port.sv
// Downstream neighbour of a router output port: per-VC flit FIFOs, on/off and VC-free
// status, round-robin drain. Define NOC_DS_PKT_CNT_EN to add per-VC popped-packet counters.
module noc_downstream_port #(
    parameter int VC_NUM     = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int OFF_THRESH = 2,
    parameter int DATA_W     = 32
) (
    input  logic clk,
    input  logic rst,
    noc_downstream_port_if.slave bus
`ifdef NOC_DS_PKT_CNT_EN
    ,
    output logic [VC_NUM*16-1:0] pkt_cnt_o
`endif
);
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [VW:0]   VC_LIMIT = (VW + 1)'(VC_NUM);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(OFF_THRESH);

    typedef enum logic [1:0] {L_HEAD = 2'd0, L_BODY = 2'd1, L_TAIL = 2'd2, L_HEADTAIL = 2'd3} label_t;
    typedef enum logic {PKT_IDLE = 1'b0, PKT_OPEN = 1'b1} pkt_state_t;

    // Per-VC control word; the packet FSM state lives here with the FIFO bookkeeping.
    typedef struct packed {
        pkt_state_t    pkt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] tails;
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
    } vc_ctl_t;

    vc_ctl_t           vc_q [VC_NUM];
    vc_ctl_t           vc_d [VC_NUM];
    logic [DATA_W+1:0] mem  [VC_NUM][BUF_DEPTH];

    logic [VC_NUM-1:0] pop_vc, wr_vc, accept_vc, overflow_vc, proto_vc, elig_vc;
    logic [VC_NUM-1:0] on_off_d, alloc_d;
    logic              pop, in_range, starts_pkt, load, grant_found, err_d;
    logic [VW-1:0]     rr_q, rr_d, rr_idx, grant_vc;
    logic [PW-1:0]     grant_ptr;
    logic [DATA_W+1:0] grant_entry;

    always_comb begin
        pop        = bus.out_valid_o & bus.out_ready_i;
        in_range   = {1'b0, bus.vc_id_i} < VC_LIMIT;
        starts_pkt = (bus.label_i == L_HEAD) || (bus.label_i == L_HEADTAIL);
        err_d      = bus.err_o;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_d[v]        = vc_q[v];
            pop_vc[v]      = pop && (bus.out_vc_o == VW'(v));
            wr_vc[v]       = bus.valid_flit_i && in_range && (bus.vc_id_i == VW'(v));
            // A full FIFO still takes a flit when its head leaves on the same edge.
            overflow_vc[v] = wr_vc[v] && (vc_q[v].cnt == DEPTH_C) && !pop_vc[v];
            accept_vc[v]   = wr_vc[v] && !overflow_vc[v];
            proto_vc[v]    = wr_vc[v] && (starts_pkt == (vc_q[v].pkt == PKT_OPEN));
            elig_vc[v]     = vc_q[v].cnt > {{(CW-1){1'b0}}, pop_vc[v]};
            if (accept_vc[v]) begin
                vc_d[v].wr_ptr = vc_q[v].wr_ptr + 1'b1;
                if (!proto_vc[v]) begin
                    if (bus.label_i == L_HEAD) vc_d[v].pkt = PKT_OPEN;
                    else if (bus.label_i == L_TAIL) vc_d[v].pkt = PKT_IDLE;
                end
            end
            if (pop_vc[v]) vc_d[v].rd_ptr = vc_q[v].rd_ptr + 1'b1;
            vc_d[v].cnt   = vc_q[v].cnt + CW'(accept_vc[v]) - CW'(pop_vc[v]);
            vc_d[v].tails = vc_q[v].tails + CW'(accept_vc[v] && bus.label_i[1])
                            - CW'(pop_vc[v] && bus.out_label_o[1]);
            on_off_d[v]   = (DEPTH_C - vc_d[v].cnt) > THRESH_C;
            alloc_d[v]    = (vc_d[v].pkt == PKT_IDLE) && (vc_d[v].tails == '0);
            if (overflow_vc[v] || proto_vc[v]) err_d = 1'b1;
        end
        if (bus.valid_flit_i && !in_range) err_d = 1'b1;

        // Scan from the highest offset down so the nearest eligible VC after rr_q wins.
        grant_found = 1'b0;
        grant_vc    = '0;
        rr_idx      = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            rr_idx = VW'((int'(rr_q) + i) % VC_NUM);
            if (elig_vc[rr_idx]) begin
                grant_found = 1'b1;
                grant_vc    = rr_idx;
            end
        end
        grant_ptr   = pop_vc[grant_vc] ? vc_q[grant_vc].rd_ptr + 1'b1 : vc_q[grant_vc].rd_ptr;
        grant_entry = mem[grant_vc][grant_ptr];
        load        = !bus.out_valid_o || pop;
        rr_d        = rr_q;
        if (load && grant_found)
            rr_d = (grant_vc == VW'(VC_NUM - 1)) ? '0 : grant_vc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) vc_q[v] <= '0;
            rr_q                 <= '0;
            bus.on_off_o         <= '1;
            bus.vc_allocatable_o <= '1;
            bus.out_valid_o      <= 1'b0;
            bus.out_data_o       <= '0;
            bus.out_vc_o         <= '0;
            bus.out_label_o      <= '0;
            bus.err_o            <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) vc_q[v] <= vc_d[v];
            rr_q                 <= rr_d;
            bus.on_off_o         <= on_off_d;
            bus.vc_allocatable_o <= alloc_d;
            bus.err_o            <= err_d;
            if (load) begin
                bus.out_valid_o <= grant_found;
                if (grant_found) begin
                    bus.out_data_o  <= grant_entry[DATA_W-1:0];
                    bus.out_label_o <= grant_entry[DATA_W+1:DATA_W];
                    bus.out_vc_o    <= grant_vc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++)
            if (accept_vc[v]) mem[v][vc_q[v].wr_ptr] <= {bus.label_i, bus.data_i};
    end

`ifdef NOC_DS_PKT_CNT_EN
    logic [15:0] pkt_cnt_q [VC_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) pkt_cnt_q[v] <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++)
                if (pop_vc[v] && bus.out_label_o[1]) pkt_cnt_q[v] <= pkt_cnt_q[v] + 16'd1;
        end
    end

    always_comb begin
        pkt_cnt_o = '0;
        for (int v = 0; v < VC_NUM; v++) pkt_cnt_o[v*16 +: 16] = pkt_cnt_q[v];
    end
`endif
endmodule

// File: tb/tb_noc_downstream_port.sv
// Bench for noc_downstream_port: directed scenarios plus randomized legal traffic,
// checked every cycle against a queue-based model of the port.
module tb_noc_downstream_port;
    localparam int VC_NUM     = 2;
    localparam int BUF_DEPTH  = 4;
    localparam int OFF_THRESH = 2;
    localparam int DATA_W     = 32;
    localparam int EW         = DATA_W + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_downstream_port_if #(.VC_NUM(VC_NUM), .DATA_W(DATA_W)) bus ();
`ifdef NOC_DS_PKT_CNT_EN
    logic [VC_NUM*16-1:0] pkt_cnt;
`endif

    noc_downstream_port #(
        .VC_NUM(VC_NUM), .BUF_DEPTH(BUF_DEPTH), .OFF_THRESH(OFF_THRESH), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef NOC_DS_PKT_CNT_EN
        ,
        .pkt_cnt_o(pkt_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one expected queue of {label, data} per VC plus packet bookkeeping.
    logic [EW-1:0] exp_q [VC_NUM][$];
    int  m_cnt   [VC_NUM];
    int  m_tails [VC_NUM];
    int  m_pkts  [VC_NUM];
    bit  m_open  [VC_NUM];
    bit  m_err, m_ov;
    bit  m_live = 1'b0;
    int  m_ovc, m_rr;
    logic [VC_NUM-1:0] e_on, e_al;

    bit  capture = 1'b0;
    int  seen_vc [$];
    bit  gen_open [VC_NUM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < VC_NUM; i++) t += m_cnt[i];
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VC_NUM; i++) begin
            exp_q[i].delete();
            m_cnt[i]   = 0;
            m_tails[i] = 0;
            m_pkts[i]  = 0;
            m_open[i]  = 1'b0;
        end
        m_err  = 1'b0;
        m_ov   = 1'b0;
        m_ovc  = 0;
        m_rr   = 0;
        m_live = 1'b1;
    endtask

    // Advance the model across the coming clock edge using the inputs now on the bus.
    task automatic model_step();
        int elig [VC_NUM];
        bit pop, starts;
        int pv, v, c;
        logic [1:0] lab;
        logic [EW-1:0] ent;
        pop = m_ov && bus.out_ready_i;
        pv  = m_ovc;
        for (int i = 0; i < VC_NUM; i++) elig[i] = m_cnt[i] - ((pop && pv == i) ? 1 : 0);
        if (pop) begin
            ent = exp_q[pv].pop_front();
            m_cnt[pv]--;
            if (ent[EW-1]) begin
                m_tails[pv]--;
                m_pkts[pv] = (m_pkts[pv] + 1) % 65536;
            end
        end
        if (bus.valid_flit_i) begin
            v   = int'(bus.vc_id_i);
            lab = bus.label_i;
            if (m_cnt[v] >= BUF_DEPTH) begin
                m_err = 1'b1;
            end else begin
                starts = (lab == 2'd0) || (lab == 2'd3);
                if (starts == m_open[v]) m_err = 1'b1;
                else if (lab == 2'd0) m_open[v] = 1'b1;
                else if (lab == 2'd2) m_open[v] = 1'b0;
                exp_q[v].push_back({lab, bus.data_i});
                m_cnt[v]++;
                if (lab[1]) m_tails[v]++;
            end
        end
        if (!m_ov || pop) begin
            m_ov = 1'b0;
            for (int k = 0; k < VC_NUM; k++) begin
                c = (m_rr + k) % VC_NUM;
                if (!m_ov && elig[c] > 0) begin
                    m_ov  = 1'b1;
                    m_ovc = c;
                end
            end
            if (m_ov) m_rr = (m_ovc + 1) % VC_NUM;
        end
    endtask

    // Monitor: compare the DUT's post-edge state with the model, then advance the model.
    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < VC_NUM; i++) begin
                e_on[i] = (BUF_DEPTH - m_cnt[i]) > OFF_THRESH;
                e_al[i] = !m_open[i] && (m_tails[i] == 0);
            end
            check("on_off", 64'(bus.on_off_o), 64'(e_on));
            check("vc_allocatable", 64'(bus.vc_allocatable_o), 64'(e_al));
            check("err", 64'(bus.err_o), 64'(m_err));
            check("out_valid", 64'(bus.out_valid_o), 64'(m_ov));
            if (m_ov) begin
                check("out_vc", 64'(bus.out_vc_o), 64'(m_ovc));
                check("out_flit", 64'({bus.out_label_o, bus.out_data_o}), 64'(exp_q[m_ovc][0]));
            end
`ifdef NOC_DS_PKT_CNT_EN
            for (int i = 0; i < VC_NUM; i++)
                check("pkt_cnt", 64'(pkt_cnt[i*16 +: 16]), 64'(m_pkts[i]));
`endif
        end
        if (capture && bus.out_valid_o && bus.out_ready_i) seen_vc.push_back(int'(bus.out_vc_o));
        if (rst) model_reset();
        else if (m_live) model_step();
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int vc, input logic [1:0] lab, input logic [DATA_W-1:0] d);
        bus.valid_flit_i = 1'b1;
        bus.vc_id_i      = 1'(vc);
        bus.label_i      = lab;
        bus.data_i       = d;
        idle(1);
        bus.valid_flit_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_on_off"}, 64'(bus.on_off_o), 64'(2'b11));
        check({tag, "_alloc"}, 64'(bus.vc_allocatable_o), 64'(2'b11));
        check({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'(0));
        check({tag, "_err"}, 64'(bus.err_o), 64'(0));
        check({tag, "_out_fields"}, 64'({bus.out_data_o, bus.out_vc_o, bus.out_label_o}), 64'(0));
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready_i = 1'b1;
        while ((m_ov || model_total() > 0) && n < 100) begin
            idle(1);
            n++;
        end
        check("drain_done", 64'(n < 100), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation stalled");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int v;
        logic [1:0] lab;
        int exp_arb [6] = '{0, 1, 0, 1, 0, 1};

        bus.valid_flit_i = 1'b0;
        bus.data_i       = '0;
        bus.vc_id_i      = '0;
        bus.label_i      = 2'd0;
        bus.out_ready_i  = 1'b0;
        do_reset();
        check_reset_values("reset");

        // Reset in the middle of a packet on VC1.
        send(1, 2'd0, 32'h1111_0000);
        send(1, 2'd1, 32'h1111_0001);
        do_reset();
        check_reset_values("reset_mid_pkt");

        // Back-pressure and overflow on VC0 with the sink stalled.
        send(0, 2'd0, 32'hA000_0000);
        check("on_off0_after_1", 64'(bus.on_off_o[0]), 64'(1));
        send(0, 2'd1, 32'hA000_0001);
        check("on_off0_after_2", 64'(bus.on_off_o[0]), 64'(0));
        send(0, 2'd1, 32'hA000_0002);
        send(0, 2'd1, 32'hA000_0003);
        check("err_after_4th", 64'(bus.err_o), 64'(0));
        send(0, 2'd2, 32'hA000_0004);
        check("err_after_5th", 64'(bus.err_o), 64'(1));
        do_reset();
        check("err_cleared", 64'(bus.err_o), 64'(0));

        // VC allocation across a three-flit packet on VC1.
        send(1, 2'd0, 32'hB000_0000);
        check("alloc1_after_head", 64'(bus.vc_allocatable_o[1]), 64'(0));
        send(1, 2'd1, 32'hB000_0001);
        send(1, 2'd2, 32'hB000_0002);
        check("alloc1_after_tail_in", 64'(bus.vc_allocatable_o[1]), 64'(0));
        bus.out_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid_o && bus.out_vc_o == 1'b1 && bus.out_label_o == 2'd2) begin
                found = 1'b1;
                check("alloc1_tail_popping", 64'(bus.vc_allocatable_o[1]), 64'(0));
                @(posedge clk);
                #1;
                check("alloc1_after_tail_pop", 64'(bus.vc_allocatable_o[1]), 64'(1));
            end
        end
        check("tail_seen", 64'(found), 64'(1));
        idle(1);
        drain();

        // Round-robin between two VCs of single-flit packets.
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, 2'd3, 32'hC000_0000 + 32'(i));
            send(1, 2'd3, 32'hC100_0000 + 32'(i));
        end
        seen_vc.delete();
        capture = 1'b1;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 30 && seen_vc.size() < 6; i++) idle(1);
        capture = 1'b0;
        check("arb_count", 64'(seen_vc.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            check("arb_order", 64'((i < seen_vc.size()) ? seen_vc[i] : -1), 64'(exp_arb[i]));
        drain();

        // Output held stable while the sink stalls.
        bus.out_ready_i = 1'b0;
        send(0, 2'd0, 32'hCAFE_0001);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(bus.out_valid_o), 64'(1));
            check("stall_fields", 64'({bus.out_data_o, bus.out_vc_o, bus.out_label_o}),
                  64'({32'hCAFE_0001, 1'b0, 2'd0}));
            idle(1);
        end
        send(0, 2'd2, 32'hCAFE_0002);
        drain();

        // Protocol error: BODY on an idle VC is flagged but still delivered.
        do_reset();
        send(0, 2'd1, 32'hD000_0000);
        check("err_body_idle", 64'(bus.err_o), 64'(1));
        drain();
        do_reset();
        for (int i = 0; i < 3; i++) send(0, 2'd3, 32'hE000_0000 + 32'(i));
        drain();
        idle(1);
`ifdef NOC_DS_PKT_CNT_EN
        check("pkt_cnt_vc0", 64'(pkt_cnt[15:0]), 64'(3));
        check("pkt_cnt_vc1", 64'(pkt_cnt[31:16]), 64'(0));
`endif

        // Randomized legal traffic honouring on_off_o.
        do_reset();
        for (int i = 0; i < VC_NUM; i++) gen_open[i] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            bus.out_ready_i  = ($urandom_range(0, 3) != 0);
            bus.valid_flit_i = 1'b0;
            if ($urandom_range(0, 2) != 0) begin
                v = int'($urandom_range(0, VC_NUM - 1));
                if (bus.on_off_o[v]) begin
                    if (!gen_open[v]) lab = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
                    else lab = ($urandom_range(0, 2) == 0) ? 2'd2 : 2'd1;
                    gen_open[v]      = (lab == 2'd0) || (lab == 2'd1);
                    bus.valid_flit_i = 1'b1;
                    bus.vc_id_i      = 1'(v);
                    bus.label_i      = lab;
                    bus.data_i       = $urandom();
                end
            end
            idle(1);
        end
        bus.valid_flit_i = 1'b0;
        drain();
        idle(2);
        check("final_err", 64'(bus.err_o), 64'(0));
        check("final_idle", 64'(bus.out_valid_o), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
